player_bullet: RTL and testbench
================================

# player_bullet

Player-bullet controller for Space Invaders: launches a single bullet from the cannon on a fire press, moves it up once per frame, and drives the bullet coordinates that the enemy columns use for hit detection. It consumes the columns' OR-reduced hit flag, shows a short explosion, and renders its own pixel for the VGA mux. It sits between the player/cannon logic and the enemy array.

## Interface
- SPEED, 4: pixels moved up per frame update
- BULLET_H, 4: bullet height in pixels (1 pixel wide)
- LAUNCH_Y, 200: by loaded at launch
- TOP_Y, 8: at or above this line the bullet is a miss
- GUN_OFS, 5: bx = player_x + GUN_OFS at launch
- EXPLODE_FRAMES, 8: frame updates the explosion is shown

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- fire  in  1  fire button, level, synchronised upstream
- player_x  in  10  cannon left edge
- vga_x  in  10  current scan column
- vga_y  in  9  current scan row
- b_hit  in  1  OR of all enemy-column hit flags, combinational on bx/by vs scan
- bx  out  10  bullet x; PARK_X when not flying
- by  out  9  bullet top y; PARK_Y when not flying
- active  out  1  high while FLY
- shot  out  1  one-clk pulse on launch
- pixel  out  1  bullet or explosion pixel at (vga_x, vga_y)
- shots  out  8  saturating count of launches
- hits  out  8  saturating count of hits

## Operation
- tick = (vga_x == 240 && vga_y == 180); all motion and explosion timing advance on tick only, in the same cycle the enemies update.
- fire_edge = fire & ~fire_q; fire_q registered every clk. Holding fire does not autofire.
- States: IDLE, FLY, BOOM.
- IDLE: bx/by = PARK_X/PARK_Y. fire_edge (any clk) -> FLY; bx <= player_x + GUN_OFS, by <= LAUNCH_Y, shot = 1 for that cycle, shots += 1 (hold at 255).
- FLY: b_hit sampled every clk. b_hit -> BOOM; ex/ey <= bx/by; bx/by <= park; hits += 1 (hold at 255); boom_cnt <= EXPLODE_FRAMES - 1. Else on tick: if by < TOP_Y + SPEED -> IDLE (miss); else by <= by - SPEED. fire_edge ignored; no queueing.
- BOOM: bx/by parked so no further enemy hits. On tick: boom_cnt == 0 -> IDLE, else decrement. fire_edge ignored.
- b_hit outside FLY is ignored.
- Priority in FLY when b_hit and tick coincide: hit wins, no move.
- pixel: FLY -> vga_x == bx && by <= vga_y < by + BULLET_H (9-bit compare, no wrap). BOOM -> |vga_x - ex| <= 1 && |vga_y - ey| <= 1 (3x3 block). IDLE -> 0. Combinational.
- Subtraction by - SPEED only after the TOP_Y guard; by never underflows.

## Timing
- Reset (async assert): state IDLE, bx = PARK_X (10'h3FF), by = PARK_Y (9'h1FF), active 0, shot 0, pixel 0, shots 0, hits 0, fire_q 0, boom_cnt 0. Deassert synchronous to clk. Reset mid-flight drops the bullet immediately; no hit counted.
- Launch: fire rises at edge N -> bx/by/active valid after edge N+1; shot high in the cycle following edge N+1 only (registered pulse, one clk).
- Hit: b_hit high in cycle N -> bx/by parked and active low after edge N+1; hits updated same edge.
- Motion: by changes only at the clk edge where tick is high; one SPEED step per frame.
- Explosion visible for exactly EXPLODE_FRAMES ticks after the hit.

## Structure
- spaceinv_pkg: UPDATE_X = 240, UPDATE_Y = 180, PARK_X, PARK_Y, coordinate widths (10/9), bullet_state_t enum {IDLE, FLY, BOOM}.
- Sub-module: rise_edge (1-bit registered rising-edge detector, async reset) for fire; reusable for the cannon's controls.
- Saturating 8-bit counters inline.

## Test plan
- Reset, then fire rise with player_x = 100 -> next edge bx = 105, by = 200, active 1, shot pulse 1 clk, shots = 1.
- Fly with no hit: after 1 tick by = 196; after 48 ticks by = 8; next tick (8 < 12) -> IDLE, bx/by = 3FF/1FF, hits = 0.
- Hold fire high for 3 frames across a miss -> only one launch; release and press again -> second launch, shots = 2.
- Pulse b_hit 1 clk at by = 120 coincident with tick -> BOOM, ex/ey = 105/120, by not decremented, hits = 1; pixel high for (104..106, 119..121); IDLE after exactly 8 ticks.
- Fire pulse and b_hit during BOOM -> no launch, hits unchanged; assert reset mid-FLY between clk edges -> outputs park immediately, counters 0.
- Saturation: 260 launches -> shots holds at 255.

Source files
------------

// File: rtl/spaceinv_pkg.sv
// spaceinv_pkg: shared coordinates, park positions and bullet state type for the invaders datapath
package spaceinv_pkg;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int UPDATE_X = 240;
  localparam int UPDATE_Y = 180;
  localparam logic [XW-1:0] PARK_X = 10'h3FF;
  localparam logic [YW-1:0] PARK_Y = 9'h1FF;
  typedef enum logic [1:0] {IDLE, FLY, BOOM} bullet_state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
  function automatic logic near1(input logic [10:0] a, input logic [10:0] b);
    return (a + 11'd1 >= b) && (a <= b + 11'd1);
  endfunction
endpackage

// File: rtl/rise_edge.sv
// rise_edge: registers a level input and flags the cycle where it first goes high
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q;
  // previous-cycle copy of the input
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/player_bullet.sv
// player_bullet: single player bullet launch, flight, hit explosion and pixel render
module player_bullet
  import spaceinv_pkg::*;
#(
  parameter int SPEED          = 4,
  parameter int BULLET_H       = 4,
  parameter int LAUNCH_Y       = 200,
  parameter int TOP_Y          = 8,
  parameter int GUN_OFS        = 5,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fire,
  input  logic [XW-1:0] player_x,
  input  logic [XW-1:0] vga_x,
  input  logic [YW-1:0] vga_y,
  input  logic          b_hit,
  output logic [XW-1:0] bx,
  output logic [YW-1:0] by,
  output logic          active,
  output logic          shot,
  output logic          pixel,
  output logic [7:0]    shots,
  output logic [7:0]    hits
);
  bullet_state_t state, state_d;
  logic [XW-1:0] bx_d, ex, ex_d;
  logic [YW-1:0] by_d, ey, ey_d;
  logic [7:0]    boom_cnt, cnt_d;
  logic          fire_edge, tick, launch, hit;
  logic [YW:0]   by_end;
  logic          fly_pix, boom_pix;

  rise_edge u_fire (
    .clk  (clk),
    .reset(reset),
    .d    (fire),
    .rise (fire_edge)
  );

  // frame update strobe shared with the enemy array
  assign tick = (vga_x == XW'(UPDATE_X)) && (vga_y == YW'(UPDATE_Y));
  assign active = (state == FLY);

  // next state and datapath: hit beats motion, motion only on tick, fire only from IDLE
  always_comb begin
    state_d = state;
    bx_d    = bx;
    by_d    = by;
    ex_d    = ex;
    ey_d    = ey;
    cnt_d   = boom_cnt;
    launch  = 1'b0;
    hit     = 1'b0;
    case (state)
      IDLE: begin
        if (fire_edge) begin
          state_d = FLY;
          bx_d    = player_x + XW'(GUN_OFS);
          by_d    = YW'(LAUNCH_Y);
          launch  = 1'b1;
        end
      end
      FLY: begin
        if (b_hit) begin
          state_d = BOOM;
          ex_d    = bx;
          ey_d    = by;
          bx_d    = PARK_X;
          by_d    = PARK_Y;
          cnt_d   = 8'(EXPLODE_FRAMES - 1);
          hit     = 1'b1;
        end else if (tick) begin
          if (by < YW'(TOP_Y + SPEED)) begin
            state_d = IDLE;
            bx_d    = PARK_X;
            by_d    = PARK_Y;
          end else begin
            by_d = by - YW'(SPEED);
          end
        end
      end
      BOOM: begin
        if (tick) begin
          state_d = (boom_cnt == 8'd0) ? IDLE : BOOM;
          cnt_d   = (boom_cnt == 8'd0) ? boom_cnt : boom_cnt - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        bx_d    = PARK_X;
        by_d    = PARK_Y;
      end
    endcase
  end

  // state, coordinates and saturating launch/hit counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bx       <= PARK_X;
      by       <= PARK_Y;
      ex       <= '0;
      ey       <= '0;
      boom_cnt <= '0;
      shot     <= 1'b0;
      shots    <= '0;
      hits     <= '0;
    end else begin
      state    <= state_d;
      bx       <= bx_d;
      by       <= by_d;
      ex       <= ex_d;
      ey       <= ey_d;
      boom_cnt <= cnt_d;
      shot     <= launch;
      shots    <= launch ? sat_inc(shots) : shots;
      hits     <= hit ? sat_inc(hits) : hits;
    end
  end

  // bullet column segment while flying, 3x3 block around the hit point while exploding
  assign by_end   = {1'b0, by} + (YW+1)'(BULLET_H);
  assign fly_pix  = (vga_x == bx) && (vga_y >= by) && ({1'b0, vga_y} < by_end);
  assign boom_pix = near1(11'(vga_x), 11'(ex)) && near1(11'(vga_y), 11'(ey));
  assign pixel    = (state == FLY) ? fly_pix : (state == BOOM) ? boom_pix : 1'b0;
endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed and random stimulus checked against a frame-level bullet model
module tb_player_bullet;
  logic       clk = 1'b0, reset = 1'b1, fire = 1'b0, b_hit = 1'b0;
  logic [9:0] player_x = '0, vga_x = '0;
  logic [8:0] vga_y = '0;
  logic [9:0] bx;
  logic [8:0] by;
  logic       active, shot, pixel;
  logic [7:0] shots, hits;
  int n_pass = 0, n_chk = 0;
  int m_ph, m_x, m_fr, m_ex, m_ey, m_left, m_shots, m_hits;
  bit m_shot, m_fq;

  player_bullet dut (
    .clk(clk), .reset(reset), .fire(fire), .player_x(player_x), .vga_x(vga_x), .vga_y(vga_y),
    .b_hit(b_hit), .bx(bx), .by(by), .active(active), .shot(shot), .pixel(pixel),
    .shots(shots), .hits(hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int m_y();
    return 200 - 4 * m_fr;
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic bit m_pix();
    if (m_ph == 1) return int'(vga_x) == m_x && int'(vga_y) >= m_y() && int'(vga_y) < m_y() + 4;
    if (m_ph == 2) return iabs(int'(vga_x) - m_ex) <= 1 && iabs(int'(vga_y) - m_ey) <= 1;
    return 1'b0;
  endfunction

  // model: phase 0 parked, 1 flying m_fr frames, 2 exploding with m_left frames to go
  always @(posedge clk or posedge reset) begin : model
    bit e, t;
    if (reset) begin
      m_ph = 0; m_x = 0; m_fr = 0; m_ex = 0; m_ey = 0; m_left = 0;
      m_shots = 0; m_hits = 0; m_shot = 0; m_fq = 0;
    end else begin
      e = fire && !m_fq;
      m_fq = fire;
      t = (vga_x == 240) && (vga_y == 180);
      m_shot = 0;
      if (m_ph == 0) begin
        if (e) begin
          m_ph = 1; m_x = (int'(player_x) + 5) % 1024; m_fr = 0; m_shot = 1;
          if (m_shots < 255) m_shots++;
        end
      end else if (m_ph == 1) begin
        if (b_hit) begin
          m_ph = 2; m_ex = m_x; m_ey = m_y(); m_left = 8;
          if (m_hits < 255) m_hits++;
        end else if (t) begin
          if (m_y() < 12) m_ph = 0;
          else m_fr++;
        end
      end else if (t) begin
        m_left--;
        if (m_left == 0) m_ph = 0;
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) if (!reset) begin
    chk("bx", bx, m_ph == 1 ? m_x : 1023);
    chk("by", by, m_ph == 1 ? m_y() : 511);
    chk("active", active, m_ph == 1);
    chk("shot", shot, m_shot);
    chk("pixel", pixel, m_pix());
    chk("shots", shots, m_shots);
    chk("hits", hits, m_hits);
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      vga_x = 240; vga_y = 180;
      nxt();
    end
    vga_x = 0; vga_y = 0;
  endtask

  initial begin
    repeat (3) nxt();
    chk("rst_bx", bx, 10'h3FF);
    chk("rst_by", by, 9'h1FF);
    chk("rst_active", active, 0);
    chk("rst_shot", shot, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_shots", shots, 0);
    chk("rst_hits", hits, 0);
    reset = 0;
    nxt();
    player_x = 100; fire = 1;
    nxt();
    chk("lit_launch_bx", bx, 105);
    chk("lit_launch_by", by, 200);
    chk("lit_launch_active", active, 1);
    chk("lit_launch_shot", shot, 1);
    chk("lit_launch_shots", shots, 1);
    nxt();
    chk("lit_shot_one_clk", shot, 0);
    tk(1);
    chk("lit_by_1tick", by, 196);
    tk(47);
    chk("lit_by_48tick", by, 8);
    tk(1);
    chk("lit_miss_bx", bx, 10'h3FF);
    chk("lit_miss_by", by, 9'h1FF);
    chk("lit_miss_active", active, 0);
    chk("lit_miss_hits", hits, 0);
    tk(3);
    chk("lit_hold_no_autofire", shots, 1);
    fire = 0;
    nxt();
    fire = 1;
    nxt();
    fire = 0;
    chk("lit_second_shots", shots, 2);
    chk("lit_second_by", by, 200);
    tk(20);
    chk("lit_by_120", by, 120);
    b_hit = 1; vga_x = 240; vga_y = 180;
    nxt();
    b_hit = 0; vga_x = 0; vga_y = 0;
    chk("lit_hit_active", active, 0);
    chk("lit_hit_by", by, 9'h1FF);
    chk("lit_hit_hits", hits, 1);
    for (int dx = -2; dx <= 2; dx++)
      for (int dy = -2; dy <= 2; dy++) begin
        vga_x = 10'(105 + dx); vga_y = 9'(120 + dy);
        nxt();
        chk("lit_boom_pix", pixel, (iabs(dx) <= 1 && iabs(dy) <= 1) ? 1 : 0);
      end
    fire = 1; b_hit = 1;
    nxt();
    fire = 0; b_hit = 0;
    nxt();
    chk("lit_boom_no_launch", shots, 2);
    chk("lit_boom_no_hit", hits, 1);
    tk(7);
    vga_x = 105; vga_y = 120;
    nxt();
    chk("lit_boom_7ticks", pixel, 1);
    tk(1);
    vga_x = 105; vga_y = 120;
    nxt();
    chk("lit_boom_8ticks", pixel, 0);
    vga_x = 0; vga_y = 0; fire = 1;
    nxt();
    fire = 0;
    chk("lit_relaunch", active, 1);
    tk(2);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("lit_async_bx", bx, 10'h3FF);
    chk("lit_async_by", by, 9'h1FF);
    chk("lit_async_active", active, 0);
    chk("lit_async_shots", shots, 0);
    chk("lit_async_hits", hits, 0);
    nxt();
    reset = 0;
    nxt();
    repeat (260) begin
      fire = 1;
      nxt();
      fire = 0; b_hit = 1;
      nxt();
      b_hit = 0;
      tk(8);
    end
    nxt();
    chk("lit_shots_sat", shots, 255);
    chk("lit_hits_sat", hits, 255);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      if ($urandom_range(0, 4) == 0) fire = ~fire;
      b_hit = ($urandom_range(0, 19) == 0);
      player_x = 10'($urandom_range(0, 1023));
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        vga_x = 240; vga_y = 180;
      end else if (sel == 1 && m_ph == 1) begin
        vga_x = 10'(m_x + int'($urandom_range(0, 2)) - 1);
        vga_y = 9'(m_y() + int'($urandom_range(0, 5)) - 1);
      end else if (sel == 1 && m_ph == 2) begin
        vga_x = 10'(m_ex + int'($urandom_range(0, 4)) - 2);
        vga_y = 9'(m_ey + int'($urandom_range(0, 4)) - 2);
      end else begin
        vga_x = 10'($urandom_range(0, 1023));
        vga_y = 9'($urandom_range(0, 511));
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1;
        nxt();
        reset = 0;
      end
      nxt();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
